// File: rtl/sram_arbiter.sv
// Two-port word-to-halfword sequencer for a 16-bit asynchronous SRAM, with read-modify-write for partial halves.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [16:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic [3:0]  i_p0_wstrb,
    output logic        o_p0_ack,
    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [16:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    input  logic [3:0]  i_p1_wstrb,
    output logic        o_p1_ack,
    output logic [31:0] o_rdata,
    output logic [17:0] o_sram_a,
    output logic [15:0] o_sram_d,
    output logic        o_sram_d_oe,
    input  logic [15:0] i_sram_d,
    output logic        o_sram_csn,
    output logic        o_sram_oen,
    output logic        o_sram_wen
);
    typedef enum logic [1:0] {IDLE, PH_STROBE, PH_RECOV, ACK} state_t;
    localparam logic [3:0] WMAX = 4'(WAIT_CYCLES);

    // Pending-phase mask, executed lowest bit first: 0 lo-read, 1 lo-write, 2 hi-read, 3 hi-write.
    // A phase index has bit 0 set for writes and bit 1 set for the high half.
    function automatic logic [3:0] build_ph(input logic we, input logic [3:0] s);
        if (!we) return 4'b0101;
        return {s[3] | s[2], s[3] ^ s[2], s[1] | s[0], s[1] ^ s[0]};
    endfunction

    function automatic logic [1:0] first_ph(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] wd, input logic [1:0] s,
                                          input logic [15:0] rd);
        return {s[1] ? wd[15:8] : rd[15:8], s[0] ? wd[7:0] : rd[7:0]};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  ph_q, ph_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [1:0]  cur, cur_d;
    logic        grant_p1, in_ph_d;
    logic        csn_d, oen_d, wen_d, doe_d, ack0_d, ack1_d;
    logic [17:0] a_d;
    logic [15:0] sd_d;
    logic [31:0] rdata_d;

`ifdef SRAM_ARB_RR_EN
    logic prio_q, prio_d;
    assign grant_p1 = i_p1_req && (!i_p0_req || prio_q);
`else
    assign grant_p1 = i_p1_req && !i_p0_req;
`endif

    assign cur = first_ph(ph_q);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rbuf_d  = rbuf_q;
`ifdef SRAM_ARB_RR_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_p0_req || i_p1_req) begin
                    gnt_d   = grant_p1;
                    we_d    = grant_p1 ? i_p1_we    : i_p0_we;
                    addr_d  = grant_p1 ? i_p1_addr  : i_p0_addr;
                    wdata_d = grant_p1 ? i_p1_wdata : i_p0_wdata;
                    wstrb_d = grant_p1 ? i_p1_wstrb : i_p0_wstrb;
                    ph_d    = build_ph(we_d, wstrb_d);
                    cnt_d   = 4'd0;
                    state_d = (ph_d == 4'd0) ? ACK : PH_STROBE;
`ifdef SRAM_ARB_RR_EN
                    prio_d  = !grant_p1;
`endif
                end
            end
            PH_STROBE: begin
                if (cnt_q == WMAX) begin
                    state_d = PH_RECOV;
                    // Read data is captured on the edge that ends the last strobe cycle.
                    if (!cur[0]) begin
                        if (cur[1]) rbuf_d[31:16] = i_sram_d;
                        else        rbuf_d[15:0]  = i_sram_d;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PH_RECOV: begin
                ph_d    = ph_q & ~(4'b0001 << cur);
                cnt_d   = 4'd0;
                state_d = (ph_d == 4'd0) ? ACK : PH_STROBE;
            end
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so every pad is driven straight from a flop.
        cur_d   = first_ph(ph_d);
        in_ph_d = (state_d == PH_STROBE) || (state_d == PH_RECOV);
        csn_d   = !in_ph_d;
        oen_d   = !((state_d == PH_STROBE) && !cur_d[0]);
        wen_d   = !((state_d == PH_STROBE) && cur_d[0]);
        doe_d   = in_ph_d && cur_d[0];
        a_d     = in_ph_d ? {addr_d, cur_d[1]} : o_sram_a;
        sd_d    = o_sram_d;
        if (doe_d)
            sd_d = cur_d[1] ? merge(wdata_d[31:16], wstrb_d[3:2], rbuf_d[31:16])
                            : merge(wdata_d[15:0],  wstrb_d[1:0], rbuf_d[15:0]);
        ack0_d  = (state_d == ACK) && !gnt_d;
        ack1_d  = (state_d == ACK) && gnt_d;
        rdata_d = ((state_d == ACK) && !we_d) ? rbuf_d : o_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            ph_q        <= 4'd0;
            cnt_q       <= 4'd0;
            o_sram_csn  <= 1'b1;
            o_sram_oen  <= 1'b1;
            o_sram_wen  <= 1'b1;
            o_sram_d_oe <= 1'b0;
            o_sram_a    <= 18'd0;
            o_sram_d    <= 16'd0;
            o_p0_ack    <= 1'b0;
            o_p1_ack    <= 1'b0;
            o_rdata     <= 32'd0;
`ifdef SRAM_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cnt_q       <= cnt_d;
            o_sram_csn  <= csn_d;
            o_sram_oen  <= oen_d;
            o_sram_wen  <= wen_d;
            o_sram_d_oe <= doe_d;
            o_sram_a    <= a_d;
            o_sram_d    <= sd_d;
            o_p0_ack    <= ack0_d;
            o_p1_ack    <= ack1_d;
            o_rdata     <= rdata_d;
`ifdef SRAM_ARB_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end

    // Transaction fields only matter once a grant has loaded them.
    always_ff @(posedge i_clk) begin
        gnt_q   <= gnt_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        rbuf_q  <= rbuf_d;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the pins.
module tb_sram_arbiter;
    localparam int W = 1;
    localparam int P = W + 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [16:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic        p0_ack, p1_ack;
    logic [31:0] rdata;
    logic [17:0] sram_a;
    logic [15:0] sram_do, sram_di;
    logic        d_oe, csn, oen, wen;

    logic [15:0] mem [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_a = 18'd0;
    logic [15:0] pl_d = 16'd0;

    int vectors = 0;
    int miscompares = 0;
    int rd_pulses = 0, wr_pulses = 0, rd_cycles = 0, viol = 0;
    logic [17:0] last_wr_a = 18'd0, last_rd_a = 18'd0;
    logic prev_oen = 1'b1, prev_wen = 1'b1;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
        .i_p0_wdata(p0_wdata), .i_p0_wstrb(p0_wstrb), .o_p0_ack(p0_ack),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
        .i_p1_wdata(p1_wdata), .i_p1_wstrb(p1_wstrb), .o_p1_ack(p1_ack),
        .o_rdata(rdata), .o_sram_a(sram_a), .o_sram_d(sram_do),
        .o_sram_d_oe(d_oe), .i_sram_d(sram_di),
        .o_sram_csn(csn), .o_sram_oen(oen), .o_sram_wen(wen)
    );

    assign sram_di = (!csn && !oen) ? mem[sram_a] : 16'h0000;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (!csn && !wen) mem[sram_a] <= sram_do;
    end

    always @(negedge clk) begin
        if (!oen) rd_cycles <= rd_cycles + 1;
        if (prev_oen && !oen) begin rd_pulses <= rd_pulses + 1; last_rd_a <= sram_a; end
        if (prev_wen && !wen) begin wr_pulses <= wr_pulses + 1; last_wr_a <= sram_a; end
        if (rstn && (((!oen || !wen) && csn) || (!oen && !wen) || (!oen && d_oe)))
            viol <= viol + 1;
        prev_oen <= oen;
        prev_wen <= wen;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Starts in an IDLE cycle (cycle 0); lat is the number of edges until ack, -1 on timeout.
    task automatic do_txn(input bit port, input bit we, input logic [16:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, output int lat);
        int n;
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_wstrb = ws; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_wstrb = ws; p0_req = 1'b1;
        end
        lat = -1;
        n = 0;
        while (lat < 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
            if (port ? p1_ack : p0_ack) lat = n;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, rp, wp, rc, k, n, acks;
        int order [4];
        int exp_order [4];

        rstn = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", {31'd0, csn}, 32'd1);
        chk("rst_oen", {31'd0, oen}, 32'd1);
        chk("rst_wen", {31'd0, wen}, 32'd1);
        chk("rst_doe", {31'd0, d_oe}, 32'd0);
        chk("rst_a", {14'd0, sram_a}, 32'd0);
        chk("rst_d", {16'd0, sram_do}, 32'd0);
        chk("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle_csn", {31'd0, csn}, 32'd1);

        preload(18'h00020, 16'hBEEF);
        preload(18'h00021, 16'hDEAD);
        rp = rd_pulses; wp = wr_pulses; rc = rd_cycles;
        do_txn(1'b0, 1'b0, 17'h00010, 32'd0, 4'h0, lat);
        chk("rd_lat", lat, 2 * P + 1);
        chk("rd_data", rdata, 32'hDEADBEEF);
        chk("rd_pulses", rd_pulses - rp, 2);
        chk("rd_cycles", rd_cycles - rc, 2 * (W + 1));
        chk("rd_nowrite", wr_pulses - wp, 0);

        rp = rd_pulses; wp = wr_pulses;
        do_txn(1'b1, 1'b1, 17'h00005, 32'h12345678, 4'hF, lat);
        chk("wr_lat", lat, 2 * P + 1);
        chk("wr_lo", {16'd0, mem[18'h0000A]}, 32'h5678);
        chk("wr_hi", {16'd0, mem[18'h0000B]}, 32'h1234);
        chk("wr_pulses", wr_pulses - wp, 2);
        chk("wr_noread", rd_pulses - rp, 0);
        chk("rdata_held", rdata, 32'hDEADBEEF);

        preload(18'h00060, 16'h5555);
        preload(18'h00061, 16'h1234);
        rp = rd_pulses; wp = wr_pulses;
        do_txn(1'b0, 1'b1, 17'h00030, 32'h00AA0000, 4'b0100, lat);
        chk("rmw_lat", lat, 2 * P + 1);
        chk("rmw_hi", {16'd0, mem[18'h00061]}, 32'h12AA);
        chk("rmw_lo_kept", {16'd0, mem[18'h00060]}, 32'h5555);
        chk("rmw_rd1", rd_pulses - rp, 1);
        chk("rmw_wr1", wr_pulses - wp, 1);
        chk("rmw_rd_a", {14'd0, last_rd_a}, 32'h00061);
        chk("rmw_wr_a", {14'd0, last_wr_a}, 32'h00061);

        wp = wr_pulses; rp = rd_pulses;
        do_txn(1'b0, 1'b1, 17'h00030, 32'hFFFFFFFF, 4'b0000, lat);
        chk("empty_lat", lat, 1);
        chk("empty_nobus", (wr_pulses - wp) + (rd_pulses - rp), 0);
        chk("empty_mem", {16'd0, mem[18'h00061]}, 32'h12AA);

        preload(18'h000C1, 16'h7777);
        wp = wr_pulses;
        do_txn(1'b1, 1'b1, 17'h00060, 32'h9999ABCD, 4'b0011, lat);
        chk("half_lat", lat, P + 1);
        chk("half_lo", {16'd0, mem[18'h000C0]}, 32'hABCD);
        chk("half_hi_kept", {16'd0, mem[18'h000C1]}, 32'h7777);
        chk("half_wr1", wr_pulses - wp, 1);

        preload(18'h00080, 16'hA1B2);
        preload(18'h00081, 16'hC3D4);
        do_txn(1'b0, 1'b1, 17'h00040, 32'h11223344, 4'b0101, lat);
        chk("rmw2_lat", lat, 4 * P + 1);
        chk("rmw2_lo", {16'd0, mem[18'h00080]}, 32'hA144);
        chk("rmw2_hi", {16'd0, mem[18'h00081]}, 32'hC322);
        do_txn(1'b1, 1'b0, 17'h00040, 32'd0, 4'h0, lat);
        chk("rdback_lat", lat, 2 * P + 1);
        chk("rdback_data", rdata, 32'hC322A144);

`ifdef SRAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        order = '{2, 2, 2, 2};
        p0_we = 1'b0; p0_addr = 17'h00010; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 17'h00040; p1_req = 1'b1;
        k = 0; n = 0;
        while (k < 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (p0_ack) begin order[k] = 0; k++; end
            else if (p1_ack) begin order[k] = 1; k++; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) chk($sformatf("arb_%0d", i), order[i], exp_order[i]);

        acks = 0;
        p0_we = 1'b1; p0_addr = 17'h00050; p0_wdata = 32'hCAFEF00D; p0_wstrb = 4'hF; p0_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (p0_ack || p1_ack) acks++; end
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("mid_csn", {31'd0, csn}, 32'd1);
        chk("mid_oen", {31'd0, oen}, 32'd1);
        chk("mid_wen", {31'd0, wen}, 32'd1);
        chk("mid_doe", {31'd0, d_oe}, 32'd0);
        p0_req = 1'b0;
        rstn = 1'b1;
        repeat (12) begin
            if (p0_ack || p1_ack) acks++;
            @(posedge clk); #1;
        end
        chk("mid_noack", acks, 0);
        do_txn(1'b0, 1'b0, 17'h00010, 32'd0, 4'h0, lat);
        chk("post_lat", lat, 2 * P + 1);
        chk("post_data", rdata, 32'hDEADBEEF);

        chk("strobe_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end
endmodule
